// File: rtl/mux_seq_pkg.sv
// ---------------------------------------------------------------------------
// mux_seq_pkg
// Shared definitions for the mux41 operand sequencer:
//   state_t    - sequencer FSM states (IDLE, SINGLE, SWEEP)
//   SEL_W      - width of the {S1,S0} select
//   SEL_LAST   - last select code of a sweep
//   rec_t      - operand record {a, b, sel, sweep} at the default width
//   rec_bits() - packed record width for an arbitrary operand width
// ---------------------------------------------------------------------------
package mux_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        SWEEP  = 2'd2
    } state_t;

    localparam int SEL_W     = 2;
    localparam logic [SEL_W-1:0] SEL_LAST = 2'b11;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_DEPTH = 2;
    localparam int DEF_CNT_W = 16;

    // Field order is shared with the width-generic record used in the top:
    // a in the MSBs, sweep flag in the LSB.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
        logic [SEL_W-1:0]     sel;
        logic                 sweep;
    } rec_t;

    function automatic int rec_bits(input int width);
        return 2 * width + SEL_W + 1;
    endfunction

endpackage

// File: rtl/mux_op_fifo.sv
// ---------------------------------------------------------------------------
// mux_op_fifo
// Synchronous operand-record FIFO with asynchronous active-low reset.
//   clk, rst_n : clock / async reset (pointers cleared, FIFO empty)
//   push       : write wdata at the rising edge (ignored while full)
//   pop        : advance the read pointer at the rising edge (ignored while empty)
//   wdata      : record to store
//   rdata      : head record (valid while !empty), read combinationally
//   full/empty : occupancy flags derived from registered pointers only
// ---------------------------------------------------------------------------
module mux_op_fifo #(
    parameter int W     = 67,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry one extra wrap bit so that full and empty differ when
    // the index bits are equal.
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];

    logic do_push;
    logic do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/mux_operand_sequencer.sv
// ---------------------------------------------------------------------------
// mux_operand_sequencer
// Feeder stage for the 32-bit 4:1 operand mux (mux41). Operand records are
// queued in a small FIFO and presented to the mux on registered outputs, one
// record per downstream beat; sweep records step {S1,S0} through 00..11.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : upstream record handshake
//   in_a, in_b          : operands
//   in_sel              : {S1,S0} for single mode
//   in_sweep            : 1 = sweep the select through all four codes
//   a_out, b_out, s1, s0: registered drive to mux41
//   out_valid/out_ready : downstream beat handshake
//   busy                : FIFO non-empty or a beat is being presented
//   done_count          : completed records, wraps
//   dbg_state           : current FSM state
//
// Handshake: a transfer happens at a rising edge where valid && ready are
// both 1. A producer holding valid keeps its data stable until the transfer;
// ready never depends combinationally on valid. in_ready is !full from
// registered pointers only, so a full FIFO refuses a push even when the
// same edge pops.
// ---------------------------------------------------------------------------
module mux_operand_sequencer
    import mux_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_sel,
    input  logic             in_sweep,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             s1,
    output logic             s0,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] done_count,
    output state_t           dbg_state
);

    localparam int RW = rec_bits(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [SEL_W-1:0] sel;
        logic             sweep;
    } op_rec_t;

    op_rec_t          wr_rec;
    op_rec_t          head;
    logic [RW-1:0]    head_bits;
    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             beat;
    logic             complete;
    logic             advance;

    assign wr_rec = '{a: in_a, b: in_b, sel: in_sel, sweep: in_sweep};
    assign push   = in_valid && !fifo_full;
    assign head   = head_bits;

    mux_op_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wr_rec),
        .rdata (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A beat finishes the record in SINGLE, or in SWEEP once the last code
    // has been presented; earlier sweep beats just step the select.
    assign beat     = vld_q && out_ready;
    assign complete = beat && ((state_q == SINGLE) ||
                               ((state_q == SWEEP) && (sel_q == SEL_LAST)));
    assign advance  = beat && (state_q == SWEEP) && (sel_q != SEL_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= '0;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sel_q   <= sel_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sel_d   = sel_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        pop     = 1'b0;

        case (state_q)
            IDLE: begin
                vld_d = 1'b0;
                if (!fifo_empty) pop = 1'b1;
            end
            SINGLE, SWEEP: begin
                if (advance) begin
                    sel_d = sel_q + SEL_W'(1);
                end else if (complete) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!fifo_empty) begin
                        // Next record loads on the same edge: no bubble.
                        pop = 1'b1;
                    end else begin
                        // Data registers keep their last value while idle.
                        vld_d   = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                vld_d   = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Loading the head is common to the IDLE start and the back-to-back
        // hand-over after a completed record.
        if (pop) begin
            a_d   = head.a;
            b_d   = head.b;
            vld_d = 1'b1;
            if (head.sweep) begin
                sel_d   = '0;
                state_d = SWEEP;
            end else begin
                sel_d   = head.sel;
                state_d = SINGLE;
            end
        end
    end

    assign in_ready   = !fifo_full;
    assign a_out      = a_q;
    assign b_out      = b_q;
    assign s1         = sel_q[1];
    assign s0         = sel_q[0];
    assign out_valid  = vld_q;
    assign busy       = !fifo_empty || vld_q;
    assign done_count = cnt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_mux_operand_sequencer.sv
module tb_mux_operand_sequencer;
  import mux_seq_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;
  // Expected beat: {last_of_record, a, b, sel}
  localparam int EW = 1 + 2 * WIDTH + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic             in_valid, in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic [1:0]       in_sel;
  logic             in_sweep;
  logic [WIDTH-1:0] a_out, b_out;
  logic             s1, s0, out_valid, out_ready, busy;
  logic [CNT_W-1:0] done_count;
  state_t           dbg_state;

  mux_operand_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel), .in_sweep(in_sweep),
    .a_out(a_out), .b_out(b_out), .s1(s1), .s0(s0),
    .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done_count(done_count), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int               checks = 0;
  int               errors = 0;
  logic [EW-1:0]    exp_q[$];
  logic [CNT_W-1:0] model_done;
  int               beat_cnt = 0;
  bit               mon_en = 0;
  bit               rnd_on = 0;
  bit               saw_wrap = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  // Samples on the falling edge; every beat the DUT presents must match the
  // head of the expected queue, and accepted pushes expand into beats.
  initial begin : monitor
    logic [EW-1:0]        e;
    logic [2*WIDTH+1:0]   prev_out;
    logic [CNT_W-1:0]     prev_dc;
    bit                   prev_stall;
    prev_stall = 0;
    prev_out   = '0;
    prev_dc    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mon_en) begin
        prev_stall = 0;
      end else begin
        chk("busy", busy, (exp_q.size() != 0));
        chk("done_count", done_count, model_done);
        if (prev_stall) chk("hold", {a_out, b_out, s1, s0}, prev_out);
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h %0h sel=%0d expected none", a_out, b_out, {s1, s0});
          end else begin
            e = exp_q[0];
            chk("beat", {a_out, b_out, s1, s0}, e[EW-2:0]);
            if (out_ready) begin
              void'(exp_q.pop_front());
              beat_cnt++;
              if (e[EW-1]) model_done++;
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {a_out, b_out, s1, s0};
        if (prev_dc == '1 && done_count == '0) saw_wrap = 1;
        prev_dc = done_count;
        if (in_valid && in_ready) begin
          if (in_sweep) begin
            for (int s = 0; s < 4; s++) exp_q.push_back({(s == 3), in_a, in_b, 2'(s)});
          end else begin
            exp_q.push_back({1'b1, in_a, in_b, in_sel});
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_rec(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [1:0] sel, input logic sw);
    bit acc;
    acc = 0;
    in_a = a; in_b = b; in_sel = sel; in_sweep = sw; in_valid = 1'b1;
    for (int n = 0; n < 2000 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("push_accepted", acc, 1'b1);
  endtask

  task automatic wait_drain(input int max_cyc, output int vcyc);
    bit drained;
    drained = 0;
    vcyc = 0;
    for (int n = 0; n < max_cyc && !drained; n++) begin
      @(negedge clk);
      if (!busy) drained = 1;
      else if (out_valid) vcyc++;
    end
    chk("drain", drained, 1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a"}, a_out, 0);
    chk({tag, "_b"}, b_out, 0);
    chk({tag, "_sel"}, {s1, s0}, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done_count, 0);
  endtask

  // random back-pressure source
  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #3000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int v;
    int base;
    logic [2*WIDTH+1:0] snap;
    logic [CNT_W-1:0] start;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_sel = '0; in_sweep = 1'b0;
    model_done = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1'b1);
    mon_en = 1;

    // single mode, sel=11: beat on the second edge after the push
    @(posedge clk); #1 out_ready = 1'b1;
    push_rec(32'h5, 32'h16, 2'b11, 1'b0);
    chk("single_early", out_valid, 1'b0);
    @(posedge clk); #1;
    chk("single_valid", out_valid, 1'b1);
    chk("single_beat", {a_out, b_out, s1, s0}, {32'h5, 32'h16, 2'b11});
    @(posedge clk); #1;
    chk("single_after", out_valid, 1'b0);
    chk("single_done", done_count, 1);

    // sweep: four consecutive beats
    push_rec(32'hA, 32'hF, 2'b00, 1'b1);
    wait_drain(50, v);
    chk("sweep_beats", v, 4);
    chk("sweep_done", done_count, 2);

    // back-pressure
    @(posedge clk); #1 out_ready = 1'b0;
    push_rec(32'h1, 32'h2, 2'b01, 1'b0);
    begin
      bit seen;
      seen = 0;
      for (int n = 0; n < 10 && !seen; n++) begin
        @(negedge clk);
        seen = out_valid;
      end
      chk("bp_valid", seen, 1'b1);
    end
    snap = {a_out, b_out, s1, s0};
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("bp_stable", {a_out, b_out, s1, s0}, snap);
    end
    @(posedge clk); #1;
    push_rec(32'h3, 32'h4, 2'b10, 1'b0);
    chk("bp_ready_after_1", in_ready, 1'b1);
    push_rec(32'h6, 32'h7, 2'b00, 1'b1);
    chk("bp_full", in_ready, 1'b0);
    in_a = 32'hDEAD; in_b = 32'hBEEF; in_sel = 2'b11; in_sweep = 1'b0; in_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("bp_refuse", in_ready, 1'b0);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    wait_drain(50, v);
    chk("bp_drain_beats", v, 6);
    chk("bp_done", done_count, 5);

    // back-to-back without bubble
    @(posedge clk); #1 out_ready = 1'b0;
    push_rec(32'hA, 32'hA, 2'b10, 1'b0);
    push_rec(32'h14, 32'h12, 2'b00, 1'b0);
    out_ready = 1'b1;
    wait_drain(50, v);
    chk("b2b_beats", v, 2);
    chk("b2b_done", done_count, 7);

    // randomized traffic with random back-pressure
    @(posedge clk); #1 rnd_on = 1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
      #0;
      push_rec($urandom, $urandom, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
    end
    rnd_on = 0;
    @(posedge clk); @(posedge clk); #2 out_ready = 1'b1;
    wait_drain(3000, v);

    // reset in the middle of a sweep, after the second beat
    @(posedge clk); #1;
    base = beat_cnt;
    push_rec(32'h5, 32'h16, 2'b00, 1'b1);
    for (int n = 0; n < 20 && beat_cnt < base + 2; n++) begin
      @(posedge clk); #1;
    end
    chk("mid_sweep_beats", beat_cnt - base, 2);
    chk("mid_sweep_sel", {out_valid, s1, s0}, 3'b110);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    exp_q.delete();
    model_done = '0;
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_in_ready", in_ready, 1'b1);

    // counter wrap: 65536 single records
    @(posedge clk); #1 out_ready = 1'b1;
    start = model_done;
    saw_wrap = 0;
    for (int i = 0; i < 65536; i++) begin
      push_rec($urandom, $urandom, 2'($urandom_range(0, 3)), 1'b0);
    end
    wait_drain(100, v);
    chk("wrap_count", done_count, start);
    chk("wrap_seen", saw_wrap, 1'b1);

    mon_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
